// File: rtl/audio_tone_gen_if.sv
// Note-stream link between the note player (master) and the tone generator (slave).
// The request signals run toward the generator, and the speaker and status signals come back.
interface audio_tone_gen_if #(
   parameter int unsigned NOTE_W = 20
);
   logic              enable;
   logic [NOTE_W-1:0] note;
   logic              spk;
   logic              active;
   logic              note_strobe;
   logic [NOTE_W-1:0] cur_note;

   modport master (
      output enable,
      output note,
      input  spk,
      input  active,
      input  note_strobe,
      input  cur_note
   );

   modport slave (
      input  enable,
      input  note,
      output spk,
      output active,
      output note_strobe,
      output cur_note
   );
endinterface

// File: rtl/audio_tone_gen.sv
// Glitch-free square-wave speaker driver. The note word is a half-period in clk cycles.
// Note changes are adopted only at half-period boundaries, and an optional silent gap separates two different notes.
module audio_tone_gen #(
   parameter int unsigned NOTE_W     = 20,
   parameter int unsigned MIN_HALF   = 2,
   parameter int unsigned GAP_CYCLES = 500000
) (
   input logic              clk,
   input logic              rst,
   audio_tone_gen_if.slave  bus
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [NOTE_W-1:0] MIN_NOTE = NOTE_W'(MIN_HALF);

   generate
      if (MIN_HALF < 1) begin : g_bad_min_half
         $error("audio_tone_gen: MIN_HALF must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e            state_q;
   logic              spk_q;
   logic              active_q;
   logic              strobe_q;
   logic [NOTE_W-1:0] cur_note_q;
   logic [NOTE_W-1:0] cnt_q;
   logic [GAP_W-1:0]  gap_cnt_q;

   logic valid;
   logic boundary;
   logic same_note;

   assign valid     = bus.enable && (bus.note >= MIN_NOTE);
   // cur_note_q is at least MIN_HALF (>= 1) whenever PLAY is active, so the subtraction cannot wrap.
   assign boundary  = (cnt_q == (cur_note_q - NOTE_W'(1)));
   assign same_note = (bus.note == cur_note_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         spk_q      <= 1'b0;
         active_q   <= 1'b0;
         strobe_q   <= 1'b0;
         cur_note_q <= '0;
         cnt_q      <= '0;
         gap_cnt_q  <= '0;
      end else begin
         strobe_q <= 1'b0;
         case (state_q)
            IDLE: begin
               spk_q    <= 1'b0;
               active_q <= 1'b0;
               if (valid) begin
                  cur_note_q <= bus.note;
                  cnt_q      <= '0;
                  strobe_q   <= 1'b1;
                  active_q   <= 1'b1;
                  state_q    <= PLAY;
               end
            end

            PLAY: begin
               if (boundary) begin
                  cnt_q <= '0;
                  if (!valid) begin
                     spk_q      <= 1'b0;
                     cur_note_q <= '0;
                     active_q   <= 1'b0;
                     state_q    <= IDLE;
                  end else if (same_note) begin
                     spk_q <= ~spk_q;
                  end else if (GAP_CYCLES > 0) begin
                     spk_q      <= 1'b0;
                     gap_cnt_q  <= '0;
                     cur_note_q <= '0;
                     active_q   <= 1'b0;
                     state_q    <= GAP;
                  end else begin
                     cur_note_q <= bus.note;
                     spk_q      <= ~spk_q;
                     strobe_q   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + NOTE_W'(1);
               end
            end

            GAP: begin
               spk_q    <= 1'b0;
               active_q <= 1'b0;
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_q <= '0;
                  if (valid) begin
                     cur_note_q <= bus.note;
                     cnt_q      <= '0;
                     strobe_q   <= 1'b1;
                     active_q   <= 1'b1;
                     state_q    <= PLAY;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end

            default: begin
               spk_q      <= 1'b0;
               active_q   <= 1'b0;
               cur_note_q <= '0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.spk         = spk_q;
   assign bus.active      = active_q;
   assign bus.note_strobe = strobe_q;
   assign bus.cur_note    = cur_note_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Drives two tone generators with identical stimulus: one with a 4-cycle gap and one with no gap.
// Each generator is compared cycle by cycle against a countdown-based model of the note rules.
module tb_audio_tone_gen;

   localparam int unsigned NW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [NW-1:0] nt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   audio_tone_gen_if #(.NOTE_W(NW)) ifg ();
   audio_tone_gen_if #(.NOTE_W(NW)) ifn ();

   assign ifg.enable = en;
   assign ifg.note   = nt;
   assign ifn.enable = en;
   assign ifn.note   = nt;

   audio_tone_gen #(.NOTE_W(NW), .MIN_HALF(2), .GAP_CYCLES(4)) dut_gap (
      .clk (clk),
      .rst (rst),
      .bus (ifg.slave)
   );

   audio_tone_gen #(.NOTE_W(NW), .MIN_HALF(2), .GAP_CYCLES(0)) dut_nogap (
      .clk (clk),
      .rst (rst),
      .bus (ifn.slave)
   );

   always #5 clk = ~clk;

   // Model state per instance: a tone flag, remaining silent-gap cycles,
   // the half-period, the remaining cycles in the current half, and the pin levels.
   bit m_tone   [2];
   int m_quiet  [2];
   int m_half   [2];
   int m_left   [2];
   bit m_spk    [2];
   bit m_strobe [2];

   task automatic model_step(input int k, input int gap);
      bit val;
      int req;
      req = int'(nt);
      val = en && (req >= 2);
      m_strobe[k] = 1'b0;
      if (rst) begin
         m_tone[k] = 1'b0; m_quiet[k] = 0; m_half[k] = 0; m_spk[k] = 1'b0;
      end else if (m_tone[k]) begin
         m_left[k] = m_left[k] - 1;
         if (m_left[k] == 0) begin
            if (!val) begin
               m_tone[k] = 1'b0; m_half[k] = 0; m_spk[k] = 1'b0;
            end else if (req == m_half[k]) begin
               m_spk[k] = ~m_spk[k]; m_left[k] = m_half[k];
            end else if (gap > 0) begin
               m_tone[k] = 1'b0; m_half[k] = 0; m_spk[k] = 1'b0; m_quiet[k] = gap;
            end else begin
               m_half[k] = req; m_left[k] = req; m_spk[k] = ~m_spk[k]; m_strobe[k] = 1'b1;
            end
         end
      end else if (m_quiet[k] > 0) begin
         m_quiet[k] = m_quiet[k] - 1;
         if (m_quiet[k] == 0 && val) begin
            m_tone[k] = 1'b1; m_half[k] = req; m_left[k] = req; m_strobe[k] = 1'b1;
         end
      end else if (val) begin
         m_tone[k] = 1'b1; m_half[k] = req; m_left[k] = req; m_strobe[k] = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("gap_spk",    32'(ifg.spk),         32'(m_spk[0]));
      chk("gap_active", 32'(ifg.active),      32'(m_tone[0]));
      chk("gap_strobe", 32'(ifg.note_strobe), 32'(m_strobe[0]));
      chk("gap_cur",    32'(ifg.cur_note),    32'(m_tone[0] ? m_half[0] : 0));
      chk("nog_spk",    32'(ifn.spk),         32'(m_spk[1]));
      chk("nog_active", 32'(ifn.active),      32'(m_tone[1]));
      chk("nog_strobe", 32'(ifn.note_strobe), 32'(m_strobe[1]));
      chk("nog_cur",    32'(ifn.cur_note),    32'(m_tone[1] ? m_half[1] : 0));
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step(0, 4);
         model_step(1, 0);
         cyc++;
         #1;
         check_all();
      end
   endtask

   initial begin
      int spins;
      rst = 1'b1; en = 1'b0; nt = '0;
      for (int k = 0; k < 2; k++) begin
         m_tone[k] = 1'b0; m_quiet[k] = 0; m_half[k] = 0;
         m_left[k] = 0; m_spk[k] = 1'b0; m_strobe[k] = 1'b0;
      end
      tick(3);
      chk("reset_cur", 32'(ifg.cur_note), 32'd0);

      // Note 5 held: a strobe one cycle after reset release, then a period of 10.
      rst = 1'b0; en = 1'b1; nt = NW'(5);
      tick(1);
      chk("first_strobe", 32'(ifg.note_strobe), 32'd1);
      tick(4);
      chk("spk_low_before_5", 32'(ifg.spk), 32'd0);
      tick(1);
      chk("spk_rise_at_5", 32'(ifg.spk), 32'd1);
      tick(16);

      // Switch to 3 mid-half: the gap instance goes silent and the no-gap instance switches in place.
      nt = NW'(3);
      tick(30);

      // Playing 4: drop enable mid-half, then re-enable.
      nt = NW'(4);
      tick(23);
      en = 1'b0;
      tick(12);
      chk("disabled_idle", 32'(ifg.active), 32'd0);
      en = 1'b1;
      tick(20);

      // Rest values from IDLE, then the smallest sounding note.
      en = 1'b0;
      tick(10);
      en = 1'b1; nt = NW'(0);
      tick(50);
      nt = NW'(1);
      tick(50);
      chk("rest_one_silent", 32'(ifg.active), 32'd0);
      nt = NW'(2);
      tick(20);

      // Reset mid-tone while spk is high.
      nt = NW'(6);
      spins = 0;
      while (!(m_spk[0] && m_tone[0]) && spins < 50) begin
         tick(1); spins++;
      end
      chk("reach_spk_high", 32'(spins < 50), 32'd1);
      tick(2);
      rst = 1'b1;
      tick(1);
      chk("rst_mid_tone_spk", 32'(ifg.spk), 32'd0);
      rst = 1'b0;
      tick(20);

      // Reset mid-gap.
      nt = NW'(3);
      spins = 0;
      while (m_quiet[0] == 0 && spins < 50) begin
         tick(1); spins++;
      end
      chk("reach_gap", 32'(spins < 50), 32'd1);
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("rst_mid_gap_act", 32'(ifg.active), 32'd0);
      rst = 1'b0;
      tick(20);

      // Random phase: small notes, enable toggles and occasional resets.
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 14) == 0) nt = NW'($urandom_range(0, 7));
         tick(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
